// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter giving two requesters shared access to one big-endian 16-bit data memory.
// Build macro DMARB_ALIGN_CHECK_EN additionally rejects odd word addresses.
module data_memory_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int MEM_BYTES = 128
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req0_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic              req1_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic              ack0_o,
   output logic              err0_o,
   output logic [DATA_W-1:0] rdata0_o,
   output logic              ack1_o,
   output logic              err1_o,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_write_o,
   output logic              mem_read_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DONE
   } state_e;

   logic [1:0]        req_w;
   logic [1:0]        we_w;
   logic [ADDR_W-1:0] addr_w  [2];
   logic [DATA_W-1:0] wdata_w [2];

   state_e            state_q;
   logic              last_q;
   logic              port_q;
   logic              we_q;
   logic              err_q;
   logic [1:0]        ack_q;
   logic [1:0]        perr_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_write_q;
   logic              mem_read_q;
   logic [DATA_W-1:0] rdata_q [2];

   logic              gnt_d;
   logic              reject_d;
   logic [1:0]        rdata_fwd;
   logic [DATA_W-1:0] rdata_w [2];

   assign req_w      = {req1_i, req0_i};
   assign we_w       = {we1_i, we0_i};
   assign addr_w[0]  = addr0_i;
   assign addr_w[1]  = addr1_i;
   assign wdata_w[0] = wdata0_i;
   assign wdata_w[1] = wdata1_i;

   // A lone requester always wins; on a tie the port not served last wins.
   always_comb begin
      if (req_w == 2'b11) begin
         gnt_d = ~last_q;
      end else begin
         gnt_d = req_w[1];
      end
      reject_d = (addr_w[gnt_d] > LAST_ADDR);
`ifdef DMARB_ALIGN_CHECK_EN
      if (addr_w[gnt_d][0]) begin
         reject_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         last_q      <= 1'b1;
         port_q      <= 1'b0;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         ack_q       <= '0;
         perr_q      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         rdata_q[0]  <= '0;
         rdata_q[1]  <= '0;
      end else begin
         // Pulses and the memory-side drive only live for the single cycle they are set up for.
         ack_q       <= '0;
         perr_q      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (|req_w) begin
                  port_q <= gnt_d;
                  we_q   <= we_w[gnt_d];
                  err_q  <= reject_d;
                  if (reject_d) begin
                     ack_q[gnt_d]  <= 1'b1;
                     perr_q[gnt_d] <= 1'b1;
                     state_q       <= S_DONE;
                  end else begin
                     mem_addr_q  <= addr_w[gnt_d];
                     mem_wdata_q <= wdata_w[gnt_d];
                     mem_write_q <= we_w[gnt_d];
                     mem_read_q  <= ~we_w[gnt_d];
                     state_q     <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               ack_q[port_q] <= 1'b1;
               state_q       <= S_DONE;
            end
            S_DONE: begin
               if (!we_q && !err_q) begin
                  rdata_q[port_q] <= mem_rdata_i;
               end
               last_q  <= port_q;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Memory data only arrives in the Ack cycle, so it is forwarded then and captured for holding.
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign rdata_fwd[gi] = ack_q[gi] && !we_q && !err_q;
      assign rdata_w[gi]   = rdata_fwd[gi] ? mem_rdata_i : rdata_q[gi];
   end

   assign ack0_o      = ack_q[0];
   assign ack1_o      = ack_q[1];
   assign err0_o      = perr_q[0];
   assign err1_o      = perr_q[1];
   assign rdata0_o    = rdata_w[0];
   assign rdata1_o    = rdata_w[1];
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_write_o = mem_write_q;
   assign mem_read_o  = mem_read_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: directed scenarios plus random two-port traffic
// checked against a byte-array reference memory updated in completion order.
module tb_data_memory_arbiter;
   localparam int MEM_BYTES = 128;

   typedef struct {
      bit          we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, we0, req1, we1;
   logic [15:0] addr0, addr1, wdata0, wdata1;
   logic        ack0, ack1, err0, err1;
   logic [15:0] rdata0, rdata1;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_write, mem_read;

   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          n_mem_wr = 0;
   int          n_mem_rd = 0;
   logic [15:0] last_mw_addr = '0;
   logic [15:0] last_mw_data = '0;

   txn_t        exp_q0[$];
   txn_t        exp_q1[$];
   int          ack_order[$];
   logic [7:0]  sim_mem [MEM_BYTES];
   logic [7:0]  ref_mem [MEM_BYTES];

   data_memory_arbiter dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req0_i      (req0),
      .we0_i       (we0),
      .addr0_i     (addr0),
      .wdata0_i    (wdata0),
      .req1_i      (req1),
      .we1_i       (we1),
      .addr1_i     (addr1),
      .wdata1_i    (wdata1),
      .ack0_o      (ack0),
      .err0_o      (err0),
      .rdata0_o    (rdata0),
      .ack1_o      (ack1),
      .err1_o      (err1),
      .rdata1_o    (rdata1),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_write_o (mem_write),
      .mem_read_o  (mem_read),
      .mem_rdata_i (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm, input string msg);
      n_tests++;
      n_fail++;
      $display("FAIL %s: %s (t=%0t)", nm, msg, $time);
   endtask

   function automatic bit exp_err(input logic [15:0] a);
      bit e;
      e = (a > 16'd126);
`ifdef DMARB_ALIGN_CHECK_EN
      if (a[0]) e = 1'b1;
`endif
      return e;
   endfunction

   // Behavioural single-port memory: registered read, big-endian byte pair.
   initial begin : mem_model
      for (int i = 0; i < MEM_BYTES; i++) sim_mem[i] = 8'($urandom_range(0, 255));
      forever begin
         @(posedge clk);
         if (mem_write && mem_addr <= 16'd126) begin
            sim_mem[mem_addr[6:0]]        <= mem_wdata[15:8];
            sim_mem[mem_addr[6:0] + 7'd1] <= mem_wdata[7:0];
         end
         if (mem_read && mem_addr <= 16'd126)
            mem_rdata <= {sim_mem[mem_addr[6:0]], sim_mem[mem_addr[6:0] + 7'd1]};
      end
   end

   // Monitor: pops expected transactions on each Ack and compares against the reference memory.
   initial begin : monitor
      txn_t        t;
      bit          e;
      logic        a, er;
      logic [15:0] rd, exp_rd;
      logic [15:0] hold [2];
      bit          prev_mw;
      bit          have;
      @(negedge clk);
      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = sim_mem[i];
      hold[0] = '0;
      hold[1] = '0;
      prev_mw = 1'b0;
      forever begin
         if (!rst_n) begin
            hold[0] = '0;
            hold[1] = '0;
            prev_mw = 1'b0;
         end else begin
            chk("dual_ack", 32'(ack0 & ack1), 32'd0);
            chk("memwrite_pulse", 32'(mem_write & prev_mw), 32'd0);
            chk("mem_rw_exclusive", 32'(mem_write & mem_read), 32'd0);
            if (mem_write || mem_read) chk("mem_addr_legal", 32'(exp_err(mem_addr)), 32'd0);
            if (mem_write) begin
               n_mem_wr++;
               last_mw_addr = mem_addr;
               last_mw_data = mem_wdata;
            end
            if (mem_read) n_mem_rd++;
            prev_mw = mem_write;
            for (int p = 0; p < 2; p++) begin
               a  = (p == 0) ? ack0 : ack1;
               er = (p == 0) ? err0 : err1;
               rd = (p == 0) ? rdata0 : rdata1;
               chk("err_without_ack", 32'(er & ~a), 32'd0);
               if (a) begin
                  have = 1'b0;
                  if (p == 0 && exp_q0.size() > 0) begin
                     t = exp_q0.pop_front();
                     have = 1'b1;
                  end else if (p == 1 && exp_q1.size() > 0) begin
                     t = exp_q1.pop_front();
                     have = 1'b1;
                  end
                  if (!have) begin
                     fail("unexpected_ack", $sformatf("port %0d acked, required no ack", p));
                  end else begin
                     e = exp_err(t.addr);
                     chk("err_flag", 32'(er), 32'(e));
                     if (!e && !t.we) begin
                        exp_rd = {ref_mem[t.addr[6:0]], ref_mem[t.addr[6:0] + 7'd1]};
                        chk("read_data", 32'(rd), 32'(exp_rd));
                        hold[p] = exp_rd;
                     end else begin
                        chk("rdata_unchanged", 32'(rd), 32'(hold[p]));
                        if (!e) begin
                           ref_mem[t.addr[6:0]]        = t.wdata[15:8];
                           ref_mem[t.addr[6:0] + 7'd1] = t.wdata[7:0];
                        end
                     end
                     ack_order.push_back(p);
                     $display("[TB] port%0d %s addr=0x%04h wdata=0x%04h rdata=0x%04h err=%0d",
                              p, t.we ? "WR" : "RD", t.addr, t.wdata, rd, er);
                  end
               end else begin
                  chk("rdata_hold", 32'(rd), 32'(hold[p]));
               end
            end
         end
         @(negedge clk);
      end
   end

   // Called at a negedge; returns at the negedge where the Ack is visible.
   task automatic issue(input int p, input bit we, input logic [15:0] addr,
                        input logic [15:0] wd, output int lat);
      txn_t t;
      int   start;
      bit   seen;
      t.we = we;
      t.addr = addr;
      t.wdata = wd;
      if (p == 0) begin
         exp_q0.push_back(t);
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
      end else begin
         exp_q1.push_back(t);
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
      end
      start = cyc;
      seen = 1'b0;
      lat = -1;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if ((p == 0 && ack0) || (p == 1 && ack1)) begin
            seen = 1'b1;
            lat = cyc - start;
         end
      end
      if (!seen) fail("ack_timeout", $sformatf("port %0d got no ack in 50 cycles, required an ack", p));
      if (p == 0) req0 = 1'b0;
      else        req1 = 1'b0;
   endtask

   task automatic rand_port(input int p, input int n);
      int          lat;
      int          r;
      bit          we;
      logic [15:0] a, d;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      a = 16'h007F;
         else if (r == 1) a = 16'($urandom_range(128, 65535));
         else             a = 16'($urandom_range(0, 126));
         we = bit'($urandom_range(0, 1));
         d  = 16'($urandom);
         issue(p, we, a, d, lat);
         if (lat > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin : main
      int lat, lat_b, cnt, base, exp_lat, exp_rd_delta;
      rst_n = 1'b0;
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'({ack0, ack1, err0, err1}), 32'd0);
      chk("rst_rdata", {rdata0, rdata1}, 32'd0);
      chk("rst_mem_bus", {mem_addr, mem_wdata}, 32'd0);
      chk("rst_mem_ctl", 32'({mem_write, mem_read}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Write then read back through port 0.
      cnt = n_mem_wr;
      issue(0, 1'b1, 16'h0010, 16'hBEEF, lat);
      chk("t1_latency", lat, 2);
      chk("t1_memwrite_count", n_mem_wr - cnt, 1);
      chk("t1_mem_addr", 32'(last_mw_addr), 32'h0010);
      chk("t1_mem_wdata", 32'(last_mw_data), 32'hBEEF);
      @(negedge clk);
      cnt = n_mem_rd;
      issue(0, 1'b0, 16'h0010, 16'h0000, lat);
      chk("t2_latency", lat, 2);
      chk("t2_memread_count", n_mem_rd - cnt, 1);
      chk("t2_rdata0", 32'(rdata0), 32'hBEEF);
      chk("t2_rdata1", 32'(rdata1), 32'h0000);

      // Range boundary on port 1.
      @(negedge clk);
      cnt = n_mem_rd + n_mem_wr;
      issue(1, 1'b0, 16'h007F, 16'h0000, lat);
      chk("t4_err_latency", lat, 1);
      chk("t4_no_mem_access", n_mem_rd + n_mem_wr - cnt, 0);
      @(negedge clk);
      cnt = n_mem_rd;
      issue(1, 1'b0, 16'h007E, 16'h0000, lat);
      chk("t4_edge_latency", lat, 2);
      chk("t4_edge_memread", n_mem_rd - cnt, 1);

      // Odd address: rejected only when alignment checking is built in.
`ifdef DMARB_ALIGN_CHECK_EN
      exp_lat = 1;
      exp_rd_delta = 0;
`else
      exp_lat = 2;
      exp_rd_delta = 1;
`endif
      @(negedge clk);
      cnt = n_mem_rd;
      issue(0, 1'b0, 16'h0011, 16'h0000, lat);
      chk("t6_latency", lat, exp_lat);
      chk("t6_memread", n_mem_rd - cnt, exp_rd_delta);

      // Reset during ISSUE of a write; data equals current contents so memory stays consistent.
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020;
      wdata0 = {ref_mem[7'h20], ref_mem[7'h21]};
      @(negedge clk);
      chk("t5_in_issue", 32'(mem_write), 32'd1);
      #1 rst_n = 1'b0;
      req0 = 1'b0;
      #1;
      chk("t5_rst_ack", 32'({ack0, ack1, err0, err1}), 32'd0);
      chk("t5_rst_rdata", {rdata0, rdata1}, 32'd0);
      chk("t5_rst_mem_ctl", 32'({mem_write, mem_read}), 32'd0);
      chk("t5_rst_mem_addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Both ports held high: port 0 first after reset, then strict alternation.
      base = ack_order.size();
      fork
         begin
            for (int i = 0; i < 4; i++) issue(0, 1'b0, 16'h0000, 16'h0000, lat);
         end
         begin
            for (int i = 0; i < 4; i++) issue(1, 1'b0, 16'h0002, 16'h0000, lat_b);
         end
      join
      @(negedge clk);
      chk("t3_grant_count", ack_order.size() - base, 8);
      for (int j = 0; j < 8 && base + j < ack_order.size(); j++)
         chk($sformatf("t3_grant_%0d", j), ack_order[base + j], j % 2);

      // Random mixed traffic on both ports.
      fork
         rand_port(0, 40);
         rand_port(1, 40);
      join
      repeat (4) @(negedge clk);
      chk("queues_drained", exp_q0.size() + exp_q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
